testbench_seq: RTL and testbench
================================

// Module: testbench_seq
// PURPOSE
//  Self-checking, parametrised successor to the testbench top. It generates A/B stimulus in
//  random, sweep or manual mode and runs a bounded or free-running test with an IDLE/RUN/DRAIN/DONE
//  sequencer. It compares i_dut_out against an inline golden model aligned to the DUT latency.
//  It counts vectors and mismatches and captures the first failing vector.
//  Sits between the host/control registers and a single arithmetic DUT.
// PARAMETERS
//  WIDTH    16  operand/result width (1..32)
//  LATENCY   2  DUT pipeline depth in cycles (0..15); 0 = combinational DUT
//  OP        0  golden op: 0 add, 1 sub (a-b), 2 mul (low WIDTH bits); all results mod 2^WIDTH
// PORTS
//  clk_dut          in   1      single clock; all logic rising-edge
//  reset            in   1      synchronous, active-high
//  i_start          in   1      1-cycle pulse: begin run (IDLE or DONE only; ignored otherwise)
//  i_stop           in   1      1-cycle pulse: end RUN early, go to DRAIN
//  i_freeze         in   1      hold all counters and first-error capture
//  i_mode           in   2      0 random, 1 sweep, 2 manual, 3 = manual; sampled at i_start
//  i_num_vec        in   32     vectors per run; 0 = run until i_stop; sampled at i_start
//  i_seed_a/i_seed_b in  32     LFSR seeds; sampled at i_start; 0 is replaced by 1
//  i_manual_a/_b    in   WIDTH  operands in manual mode (live, not sampled)
//  o_dut_a/o_dut_b  out  WIDTH  operands to DUT
//  i_dut_out        in   WIDTH  DUT result
//  o_busy           out  1      high in RUN or DRAIN
//  o_done           out  1      high in DONE
//  o_data_ctr       out  32     vectors checked
//  o_event_ctr      out  32     mismatches
//  o_err_idx        out  32     index (0-based) of first mismatching vector
//  o_err_a/o_err_b/o_err_out out WIDTH  operands and DUT result of first mismatch
//  o_err_valid      out  1      first-error fields valid
// BEHAVIOUR
//  - Reset: FSM=IDLE; every output 0; LFSRs, sweep counter, valid pipe cleared.
//  - IDLE --i_start--> RUN: clear counters/err fields; load seeds, mode and num_vec; sweep={b,a}=0.
//  - RUN: one vector per cycle on o_dut_a/b (registered). Its issue index, operands and golden
//    result enter a LATENCY-deep valid pipe. RUN->DRAIN after the i_num_vec-th vector,
//    or on i_stop (that cycle issues no vector).
//  - DRAIN: o_dut_a/b=0, no new valid; exactly LATENCY cycles, then DONE (LATENCY=0: 1 cycle).
//  - DONE: counters/err hold, o_done=1; i_start restarts as from IDLE.
//  - Random: per-operand 32-bit Galois LFSR, mask 0x80200003, shift every RUN cycle. Operand =
//    low WIDTH bits of current state. The first vector uses the seed itself.
//  - Sweep: 2*WIDTH-bit counter {b,a} +1 per vector; a varies fastest; wraps to 0 silently.
//  - Check: vector issued at cycle t is compared with i_dut_out at cycle t+LATENCY.
//    +1 data_ctr per check; +1 event_ctr per mismatch.
//  - Counters saturate at 0xFFFFFFFF. On the first mismatch of a run, latch o_err_* and
//    set o_err_valid.
//  - i_freeze: counters and capture hold. Stimulus, FSM and valid pipe keep running.
//    Checks during freeze are lost, not deferred.
//  - i_start and i_stop in the same cycle: in IDLE/DONE start wins; in RUN stop wins.
//  - Reset mid-run: aborts immediately to reset state; in-flight vectors are discarded.
// TESTING
//  1 OP=0,LATENCY=2, ideal adder, sweep, num_vec=5, start@c0 -> o_dut_a 0..4 at c1..c5, b=0;
//    DRAIN c6-c7; o_done@c8; data_ctr=5, event_ctr=0, err_valid=0.
//  2 As 1 but DUT out bit0 stuck-0 -> event_ctr=2, err_idx=1, err_a=1, err_b=0, err_out=0.
//  3 Manual a=0xFFFF b=0x0001, OP=0, num_vec=3 -> expected 0x0000, DUT 0x0000: event_ctr=0.
//    With OP=1 and DUT 0xFFFE: event_ctr=0.
//  4 Random, seeds 0xCAFEF00D/0xFEEDC0DE, num_vec=0, i_stop after 100 vectors ->
//    data_ctr=100. Vector 0 is a=0xF00D, b=0xC0DE.
//  5 Ideal DUT, i_freeze high for vectors 10..19 of 50 -> data_ctr=40. Stimulus is unchanged.
//  6 Reset at vector 7 of 20, LATENCY=3 -> next cycle all outputs 0, FSM IDLE.
//    A new i_start gives data_ctr=20.

Source files
------------

// File: rtl/testbench_seq_if.sv
// DUT-facing operand/result bus between the stimulus sequencer and the
// arithmetic block under test.
interface testbench_seq_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] o_dut_a;
  logic [WIDTH-1:0] o_dut_b;
  logic [WIDTH-1:0] i_dut_out;

  // master: the sequencer drives operands and observes the result
  modport master (output o_dut_a, output o_dut_b, input i_dut_out);
  // slave: the arithmetic DUT consumes operands and returns the result
  modport slave  (input o_dut_a, input o_dut_b, output i_dut_out);
endinterface

// File: rtl/testbench_seq.sv
// Stimulus sequencer and checker for a single pipelined arithmetic DUT.
// Issues one operand pair per RUN cycle (random / sweep / manual), carries
// the golden result down a LATENCY-deep valid pipe, compares it with the DUT
// result, counts vectors and mismatches and captures the first failure.
module testbench_seq #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int OP      = 0
) (
  input  logic              clk_dut,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_freeze,
  input  logic [1:0]        i_mode,
  input  logic [31:0]       i_num_vec,
  input  logic [31:0]       i_seed_a,
  input  logic [31:0]       i_seed_b,
  input  logic [WIDTH-1:0]  i_manual_a,
  input  logic [WIDTH-1:0]  i_manual_b,
  testbench_seq_if.master   dut_bus,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_data_ctr,
  output logic [31:0]       o_event_ctr,
  output logic [31:0]       o_err_idx,
  output logic [WIDTH-1:0]  o_err_a,
  output logic [WIDTH-1:0]  o_err_b,
  output logic [WIDTH-1:0]  o_err_out,
  output logic              o_err_valid
);

  localparam logic [31:0]        LFSR_MASK  = 32'h8020_0003;
  localparam int                 DRAIN_LEN  = (LATENCY == 0) ? 1 : LATENCY;
  localparam logic [3:0]         DRAIN_LAST = 4'(DRAIN_LEN - 1);
  localparam int                 PIPE_D     = (LATENCY == 0) ? 1 : LATENCY;
  localparam logic [2*WIDTH-1:0] SWEEP_ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // One in-flight vector: issue index, operands and expected result.
  typedef struct packed {
    logic             vld;
    logic [31:0]      idx;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] gold;
  } entry_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (OP)
      0:       return a + b;
      1:       return a - b;
      default: return a * b;
    endcase
  endfunction

  state_t             state_reg, state_next;
  logic               first, issue, load;
  logic [1:0]         mode_reg;
  logic [31:0]        num_vec_reg;
  logic [31:0]        lfsr_a_reg, lfsr_b_reg;
  logic [2*WIDTH-1:0] sweep_reg;
  logic [31:0]        idx_reg;
  logic [3:0]         drain_reg;
  logic [WIDTH-1:0]   dut_a_reg, dut_b_reg;

  logic [31:0]        seed_a_fix, seed_b_fix, src_lfsr_a, src_lfsr_b;
  logic [2*WIDTH-1:0] src_sweep;
  logic [1:0]         vec_mode;
  logic [WIDTH-1:0]   vec_a, vec_b;

  entry_t             issue_ent, chk_ent;
  entry_t             pipe_reg [PIPE_D];
  logic               mismatch;

  // A zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_a_fix = (i_seed_a == 32'd0) ? 32'd1 : i_seed_a;
  assign seed_b_fix = (i_seed_b == 32'd0) ? 32'd1 : i_seed_b;

  assign dut_bus.o_dut_a = dut_a_reg;
  assign dut_bus.o_dut_b = dut_b_reg;
  assign o_busy = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign o_done = (state_reg == S_DONE);

  // Sequencer state register and drain-length counter.
  always_ff @(posedge clk_dut) begin
    if (reset) begin
      state_reg <= S_IDLE;
      drain_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      drain_reg <= (state_reg == S_DRAIN) ? drain_reg + 4'd1 : 4'd0;
    end
  end

  // Next state; 'issue' marks the vector on the bus this cycle as a real
  // vector, 'load' fetches the following one. A stop cycle issues nothing.
  always_comb begin
    state_next = state_reg;
    first      = 1'b0;
    issue      = 1'b0;
    load       = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_next = S_RUN;
          first      = 1'b1;
        end
      end
      S_RUN: begin
        if (i_stop) begin
          state_next = S_DRAIN;
        end else begin
          issue = 1'b1;
          if (num_vec_reg != 32'd0 && idx_reg == num_vec_reg - 32'd1) begin
            state_next = S_DRAIN;
          end else begin
            load = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Select the next operand pair; on a start the freshly sampled seeds and
  // mode are used so the first vector is the seed itself / sweep zero.
  always_comb begin
    src_lfsr_a = first ? seed_a_fix : lfsr_a_reg;
    src_lfsr_b = first ? seed_b_fix : lfsr_b_reg;
    src_sweep  = first ? '0 : sweep_reg;
    vec_mode   = first ? i_mode : mode_reg;
    vec_a      = i_manual_a;
    vec_b      = i_manual_b;
    if (vec_mode == 2'd0) begin
      vec_a = src_lfsr_a[WIDTH-1:0];
      vec_b = src_lfsr_b[WIDTH-1:0];
    end else if (vec_mode == 2'd1) begin
      vec_a = src_sweep[WIDTH-1:0];
      vec_b = src_sweep[2*WIDTH-1:WIDTH];
    end
  end

  // Stimulus generators and registered operand outputs (zero when not running).
  always_ff @(posedge clk_dut) begin
    if (reset) begin
      mode_reg    <= 2'd0;
      num_vec_reg <= 32'd0;
      lfsr_a_reg  <= 32'd0;
      lfsr_b_reg  <= 32'd0;
      sweep_reg   <= '0;
      idx_reg     <= 32'd0;
      dut_a_reg   <= '0;
      dut_b_reg   <= '0;
    end else begin
      if (first) begin
        mode_reg    <= i_mode;
        num_vec_reg <= i_num_vec;
      end
      if (first || load) begin
        dut_a_reg  <= vec_a;
        dut_b_reg  <= vec_b;
        lfsr_a_reg <= lfsr_step(src_lfsr_a);
        lfsr_b_reg <= lfsr_step(src_lfsr_b);
        sweep_reg  <= src_sweep + SWEEP_ONE;
        idx_reg    <= first ? 32'd0 : idx_reg + 32'd1;
      end else if (state_next != S_RUN) begin
        dut_a_reg <= '0;
        dut_b_reg <= '0;
      end
    end
  end

  // Vector currently on the bus, tagged with its expected result.
  always_comb begin
    issue_ent      = '0;
    issue_ent.vld  = issue;
    issue_ent.idx  = idx_reg;
    issue_ent.a    = dut_a_reg;
    issue_ent.b    = dut_b_reg;
    issue_ent.gold = golden(dut_a_reg, dut_b_reg);
  end

  // Valid pipe delaying each issued vector to line up with the DUT result.
  always_ff @(posedge clk_dut) begin
    if (reset) begin
      for (int i = 0; i < PIPE_D; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[0] <= issue_ent;
      for (int i = 1; i < PIPE_D; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  generate
    if (LATENCY == 0) begin : g_comb_tap
      assign chk_ent = issue_ent;
    end else begin : g_pipe_tap
      assign chk_ent = pipe_reg[PIPE_D-1];
    end
  endgenerate

  assign mismatch = chk_ent.vld && (dut_bus.i_dut_out != chk_ent.gold);

  // Saturating counters and first-error capture; a frozen check is dropped.
  always_ff @(posedge clk_dut) begin
    if (reset || first) begin
      o_data_ctr  <= 32'd0;
      o_event_ctr <= 32'd0;
      o_err_idx   <= 32'd0;
      o_err_a     <= '0;
      o_err_b     <= '0;
      o_err_out   <= '0;
      o_err_valid <= 1'b0;
    end else if (chk_ent.vld && !i_freeze) begin
      if (o_data_ctr != 32'hFFFF_FFFF) o_data_ctr <= o_data_ctr + 32'd1;
      if (mismatch) begin
        if (o_event_ctr != 32'hFFFF_FFFF) o_event_ctr <= o_event_ctr + 32'd1;
        if (!o_err_valid) begin
          o_err_valid <= 1'b1;
          o_err_idx   <= chk_ent.idx;
          o_err_a     <= chk_ent.a;
          o_err_b     <= chk_ent.b;
          o_err_out   <= dut_bus.i_dut_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_testbench_seq.sv
// Bench for testbench_seq: two instances (adder LATENCY=2, subtractor
// LATENCY=3) share control inputs; each drives its own behavioural DUT.
// Expected results come from a vector-level model of the stimulus rules.
module tb_testbench_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, i_start, i_stop, i_freeze;
  logic [1:0] i_mode;
  logic [31:0] i_num_vec, i_seed_a, i_seed_b;
  logic [W-1:0] i_manual_a, i_manual_b;
  logic busy [2], done [2], err_valid [2];
  logic [31:0] data_ctr [2], event_ctr [2], err_idx [2];
  logic [W-1:0] err_a [2], err_b [2], err_out [2], dut_a [2], dut_b [2];

  int checks = 0, errors = 0;

  testbench_seq_if #(.WIDTH(W)) bus0 ();
  testbench_seq_if #(.WIDTH(W)) bus1 ();

  testbench_seq #(.WIDTH(W), .LATENCY(2), .OP(0)) u_add (
    .clk_dut(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop), .i_freeze(i_freeze),
    .i_mode(i_mode), .i_num_vec(i_num_vec), .i_seed_a(i_seed_a), .i_seed_b(i_seed_b),
    .i_manual_a(i_manual_a), .i_manual_b(i_manual_b), .dut_bus(bus0),
    .o_busy(busy[0]), .o_done(done[0]), .o_data_ctr(data_ctr[0]), .o_event_ctr(event_ctr[0]),
    .o_err_idx(err_idx[0]), .o_err_a(err_a[0]), .o_err_b(err_b[0]), .o_err_out(err_out[0]),
    .o_err_valid(err_valid[0]));

  testbench_seq #(.WIDTH(W), .LATENCY(3), .OP(1)) u_sub (
    .clk_dut(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop), .i_freeze(i_freeze),
    .i_mode(i_mode), .i_num_vec(i_num_vec), .i_seed_a(i_seed_a), .i_seed_b(i_seed_b),
    .i_manual_a(i_manual_a), .i_manual_b(i_manual_b), .dut_bus(bus1),
    .o_busy(busy[1]), .o_done(done[1]), .o_data_ctr(data_ctr[1]), .o_event_ctr(event_ctr[1]),
    .o_err_idx(err_idx[1]), .o_err_a(err_a[1]), .o_err_b(err_b[1]), .o_err_out(err_out[1]),
    .o_err_valid(err_valid[1]));

  assign dut_a[0] = bus0.o_dut_a;
  assign dut_b[0] = bus0.o_dut_b;
  assign dut_a[1] = bus1.o_dut_a;
  assign dut_b[1] = bus1.o_dut_b;

  // Behavioural arithmetic DUTs; fault 1 forces result bit 0 to zero.
  int fault = 0;
  logic [W-1:0] add_pipe [2];
  logic [W-1:0] sub_pipe [3];
  function automatic logic [W-1:0] faulty(input logic [W-1:0] v);
    return (fault == 1) ? (v & 16'hFFFE) : v;
  endfunction
  always @(posedge clk) begin
    add_pipe[0] <= faulty(bus0.o_dut_a + bus0.o_dut_b);
    add_pipe[1] <= add_pipe[0];
    sub_pipe[0] <= faulty(bus1.o_dut_a - bus1.o_dut_b);
    sub_pipe[1] <= sub_pipe[0];
    sub_pipe[2] <= sub_pipe[1];
  end
  assign bus0.i_dut_out = add_pipe[1];
  assign bus1.i_dut_out = sub_pipe[2];

  // Run configuration (cycle numbers are relative to the start cycle 0).
  int r_mode, r_num, r_stop, r_frz_lo, r_frz_hi, r_rst;
  logic [31:0] r_seed_a, r_seed_b;
  logic [W-1:0] r_man_a, r_man_b;

  // Recorded bus operands per cycle and expected model results.
  logic [W-1:0] rec_a [2][256];
  logic [W-1:0] rec_b [2][256];
  int done_cyc [2];
  logic [W-1:0] exp_a [256];
  logic [W-1:0] exp_b [256];
  int exp_done [2], exp_data [2], exp_event [2], exp_idx [2];
  logic exp_valid [2];
  logic [W-1:0] exp_ea [2], exp_eb [2], exp_eout [2];
  int n_vec;

  function automatic logic [31:0] galois(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic cfg_default();
    r_mode = 1; r_num = 5; r_stop = 0; r_frz_lo = 1; r_frz_hi = 0; r_rst = 0;
    r_seed_a = 32'd1; r_seed_b = 32'd1; r_man_a = '0; r_man_b = '0; fault = 0;
  endtask

  // Vector list from the stimulus rules, then per-instance expected results.
  task automatic model_run();
    logic [31:0] la, lb;
    logic [W-1:0] gold, got;
    int lat;
    la = (r_seed_a == 32'd0) ? 32'd1 : r_seed_a;
    lb = (r_seed_b == 32'd0) ? 32'd1 : r_seed_b;
    n_vec = (r_stop != 0) ? r_stop : r_num;
    for (int k = 0; k < n_vec; k++) begin
      if (r_mode == 0) begin exp_a[k] = la[W-1:0]; exp_b[k] = lb[W-1:0]; end
      else if (r_mode == 1) begin exp_a[k] = k[15:0]; exp_b[k] = k[31:16]; end
      else begin exp_a[k] = r_man_a; exp_b[k] = r_man_b; end
      la = galois(la);
      lb = galois(lb);
    end
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 2 : 3;
      exp_done[i] = (r_stop != 0) ? r_stop + lat + 2 : r_num + lat + 1;
      exp_data[i] = 0; exp_event[i] = 0; exp_idx[i] = 0; exp_valid[i] = 1'b0;
      exp_ea[i] = '0; exp_eb[i] = '0; exp_eout[i] = '0;
      for (int k = 0; k < n_vec; k++) begin
        if (1 + k + lat >= r_frz_lo && 1 + k + lat <= r_frz_hi) continue;
        gold = (i == 0) ? exp_a[k] + exp_b[k] : exp_a[k] - exp_b[k];
        got  = (fault == 1) ? (gold & 16'hFFFE) : gold;
        exp_data[i]++;
        if (got != gold) begin
          exp_event[i]++;
          if (!exp_valid[i]) begin
            exp_valid[i] = 1'b1; exp_idx[i] = k;
            exp_ea[i] = exp_a[k]; exp_eb[i] = exp_b[k]; exp_eout[i] = got;
          end
        end
      end
    end
  endtask

  // Pulse start, then per cycle record outputs and drive stop/freeze/reset.
  task automatic run_seq();
    int c;
    bit fin;
    done_cyc[0] = -1; done_cyc[1] = -1;
    @(negedge clk);
    i_mode = r_mode[1:0]; i_num_vec = r_num; i_seed_a = r_seed_a; i_seed_b = r_seed_b;
    i_manual_a = r_man_a; i_manual_b = r_man_b; i_start = 1'b1;
    c = 0; fin = 0;
    while (!fin) begin
      @(negedge clk);
      c++;
      i_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (c <= 256) begin rec_a[i][c-1] = dut_a[i]; rec_b[i][c-1] = dut_b[i]; end
        if (done[i] && done_cyc[i] < 0) done_cyc[i] = c;
      end
      i_stop   = (r_stop != 0 && c == r_stop + 1);
      i_freeze = (c >= r_frz_lo && c <= r_frz_hi);
      reset    = (r_rst != 0 && c == r_rst);
      if (done_cyc[0] >= 0 && done_cyc[1] >= 0) fin = 1;
      if (r_rst != 0 && c == r_rst + 1) fin = 1;
      if (c > 2000) begin
        checks++; errors++;
        $display("FAIL run_timeout: got no done after %0d cycles, required done", c);
        fin = 1;
      end
    end
    i_stop = 1'b0; i_freeze = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy[i], done[i], data_ctr[i], event_ctr[i], err_idx[i], err_a[i], err_b[i],
           err_out[i], err_valid[i], dut_a[i], dut_b[i]} !== '0) begin
        errors++;
        $display("FAIL reset_state inst%0d: got busy=%b done=%b data=%0d ev=%0d a=%h b=%h ev_valid=%b, required all zero",
                 i, busy[i], done[i], data_ctr[i], event_ctr[i], dut_a[i], dut_b[i], err_valid[i]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_sweep();
    cfg_default();
    model_run();
    run_seq();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (done_cyc[i] !== exp_done[i]) begin errors++;
        $display("FAIL sweep_done_cycle inst%0d: got %0d required %0d", i, done_cyc[i], exp_done[i]); end
      checks++;
      if (data_ctr[i] !== exp_data[i] || event_ctr[i] !== exp_event[i] || err_valid[i] !== exp_valid[i]) begin errors++;
        $display("FAIL sweep_counts inst%0d: got data=%0d ev=%0d v=%b required data=%0d ev=%0d v=%b",
                 i, data_ctr[i], event_ctr[i], err_valid[i], exp_data[i], exp_event[i], exp_valid[i]); end
      for (int k = 0; k < n_vec; k++) begin
        checks++;
        if (rec_a[i][k] !== exp_a[k] || rec_b[i][k] !== exp_b[k]) begin errors++;
          $display("FAIL sweep_stim inst%0d vec%0d: got a=%h b=%h required a=%h b=%h",
                   i, k, rec_a[i][k], rec_b[i][k], exp_a[k], exp_b[k]); end
      end
      checks++;
      if ({dut_a[i], dut_b[i], busy[i]} !== '0) begin errors++;
        $display("FAIL sweep_idle_bus inst%0d: got a=%h b=%h busy=%b required 0", i, dut_a[i], dut_b[i], busy[i]); end
    end
  endtask

  task automatic test_stuck_bit();
    cfg_default();
    fault = 1;
    model_run();
    run_seq();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (event_ctr[i] !== exp_event[i] || data_ctr[i] !== exp_data[i]) begin errors++;
        $display("FAIL stuck_counts inst%0d: got data=%0d ev=%0d required data=%0d ev=%0d",
                 i, data_ctr[i], event_ctr[i], exp_data[i], exp_event[i]); end
      checks++;
      if ({err_valid[i], err_idx[i], err_a[i], err_b[i], err_out[i]} !==
          {exp_valid[i], exp_idx[i], exp_ea[i], exp_eb[i], exp_eout[i]}) begin errors++;
        $display("FAIL stuck_capture inst%0d: got v=%b idx=%0d a=%h b=%h out=%h required v=%b idx=%0d a=%h b=%h out=%h",
                 i, err_valid[i], err_idx[i], err_a[i], err_b[i], err_out[i],
                 exp_valid[i], exp_idx[i], exp_ea[i], exp_eb[i], exp_eout[i]); end
    end
  endtask

  task automatic test_manual();
    for (int run = 0; run < 2; run++) begin
      cfg_default();
      r_mode = (run == 0) ? 2 : 3;
      r_man_a = (run == 0) ? 16'hFFFF : 16'($urandom);
      r_man_b = (run == 0) ? 16'h0001 : 16'($urandom);
      r_num   = (run == 0) ? 3 : int'($urandom_range(2, 10));
      model_run();
      run_seq();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (data_ctr[i] !== exp_data[i] || event_ctr[i] !== exp_event[i] || err_valid[i] !== exp_valid[i]) begin errors++;
          $display("FAIL manual_counts run%0d inst%0d: got data=%0d ev=%0d v=%b required data=%0d ev=%0d v=%b",
                   run, i, data_ctr[i], event_ctr[i], err_valid[i], exp_data[i], exp_event[i], exp_valid[i]); end
        checks++;
        if (rec_a[i][0] !== r_man_a || rec_b[i][0] !== r_man_b) begin errors++;
          $display("FAIL manual_stim run%0d inst%0d: got a=%h b=%h required a=%h b=%h",
                   run, i, rec_a[i][0], rec_b[i][0], r_man_a, r_man_b); end
      end
    end
  endtask

  task automatic test_random();
    // Free-running random run ended by i_stop after 100 vectors.
    cfg_default();
    r_mode = 0; r_num = 0; r_stop = 100;
    r_seed_a = 32'hCAFE_F00D; r_seed_b = 32'hFEED_C0DE;
    model_run();
    run_seq();
    checks++;
    if (rec_a[0][0] !== 16'hF00D || rec_b[0][0] !== 16'hC0DE) begin errors++;
      $display("FAIL random_first_vec: got a=%h b=%h required a=f00d b=c0de", rec_a[0][0], rec_b[0][0]); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (data_ctr[i] !== exp_data[i] || done_cyc[i] !== exp_done[i]) begin errors++;
        $display("FAIL random_stop inst%0d: got data=%0d done@%0d required data=%0d done@%0d",
                 i, data_ctr[i], done_cyc[i], exp_data[i], exp_done[i]); end
      for (int k = 0; k < n_vec; k++) begin
        checks++;
        if (rec_a[i][k] !== exp_a[k] || rec_b[i][k] !== exp_b[k]) begin errors++;
          $display("FAIL random_stim inst%0d vec%0d: got a=%h b=%h required a=%h b=%h",
                   i, k, rec_a[i][k], rec_b[i][k], exp_a[k], exp_b[k]); end
      end
    end
    // Zero seed on a, random seed on b, faulty DUT, random bounded length.
    cfg_default();
    r_mode = 0; r_num = int'($urandom_range(20, 60)); fault = 1;
    r_seed_a = 32'd0; r_seed_b = $urandom;
    model_run();
    run_seq();
    checks++;
    if (rec_a[0][0] !== 16'h0001) begin errors++;
      $display("FAIL zero_seed: got a=%h required 0001", rec_a[0][0]); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({data_ctr[i], event_ctr[i], err_valid[i], err_idx[i], err_a[i], err_b[i], err_out[i]} !==
          {exp_data[i], exp_event[i], exp_valid[i], exp_idx[i], exp_ea[i], exp_eb[i], exp_eout[i]}) begin errors++;
        $display("FAIL random_fault inst%0d: got data=%0d ev=%0d v=%b idx=%0d a=%h b=%h out=%h required data=%0d ev=%0d v=%b idx=%0d a=%h b=%h out=%h",
                 i, data_ctr[i], event_ctr[i], err_valid[i], err_idx[i], err_a[i], err_b[i], err_out[i],
                 exp_data[i], exp_event[i], exp_valid[i], exp_idx[i], exp_ea[i], exp_eb[i], exp_eout[i]); end
    end
  endtask

  task automatic test_freeze();
    // Freeze covers the check cycles of adder vectors 10..19.
    cfg_default();
    r_mode = 0; r_num = 50; r_frz_lo = 13; r_frz_hi = 22;
    r_seed_a = $urandom; r_seed_b = $urandom;
    model_run();
    run_seq();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (data_ctr[i] !== exp_data[i] || event_ctr[i] !== 32'd0) begin errors++;
        $display("FAIL freeze_counts inst%0d: got data=%0d ev=%0d required data=%0d ev=0",
                 i, data_ctr[i], event_ctr[i], exp_data[i]); end
      for (int k = 0; k < n_vec; k++) begin
        checks++;
        if (rec_a[i][k] !== exp_a[k] || rec_b[i][k] !== exp_b[k]) begin errors++;
          $display("FAIL freeze_stim inst%0d vec%0d: got a=%h b=%h required a=%h b=%h",
                   i, k, rec_a[i][k], rec_b[i][k], exp_a[k], exp_b[k]); end
      end
    end
  endtask

  task automatic test_reset_midrun();
    // Reset while vector 7 of 20 is on the bus (cycle 8).
    cfg_default();
    r_num = 20; r_rst = 8;
    run_seq();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy[i], done[i], data_ctr[i], event_ctr[i], err_idx[i], err_a[i], err_b[i],
           err_out[i], err_valid[i], dut_a[i], dut_b[i]} !== '0) begin errors++;
        $display("FAIL midrun_reset inst%0d: got busy=%b done=%b data=%0d a=%h b=%h, required all zero",
                 i, busy[i], done[i], data_ctr[i], dut_a[i], dut_b[i]); end
    end
    cfg_default();
    r_num = 20;
    model_run();
    run_seq();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (data_ctr[i] !== exp_data[i] || done_cyc[i] !== exp_done[i]) begin errors++;
        $display("FAIL restart_after_reset inst%0d: got data=%0d done@%0d required data=%0d done@%0d",
                 i, data_ctr[i], done_cyc[i], exp_data[i], exp_done[i]); end
    end
  endtask

  initial begin
    reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_freeze = 1'b0;
    i_mode = 2'd0; i_num_vec = '0; i_seed_a = '0; i_seed_b = '0;
    i_manual_a = '0; i_manual_b = '0;
    cfg_default();
    test_reset();
    test_sweep();
    test_stuck_bit();
    test_manual();
    test_random();
    test_freeze();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
